frame_scanout: RTL and testbench

- Reader end of the frame-buffer interface: graphics_driver writes Frame contents, and frame_scanout reads them back pixel by pixel in raster order to drive the VGA pins.
- Generates VGA sync timing and fetches pixels from a double-buffered frame store with 1-cycle read latency.
- Outputs RGB/sync aligned to each other.
- Emits the per-frame refresh pulse consumed by graphics_driver.
- Performs front/back buffer swaps only during vertical blanking.

---
 rtl/frame_scanout_pkg.sv | 38 +++
 rtl/frame_scanout_timing.sv | 63 ++++++
 rtl/frame_scanout.sv | 197 +++++++++++++++++++
 tb/tb_frame_scanout.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_scanout_pkg.sv
// Shared types and default timing for the frame scanout block.
// Defaults describe 640x480@60 VGA.
package frame_scanout_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned SCALE_DEF    = 1;
  localparam int unsigned COLOR_W_DEF  = 4;

  // Pixel as stored in the frame buffer, at the default channel width.
  typedef struct packed {
    logic [COLOR_W_DEF-1:0] r;
    logic [COLOR_W_DEF-1:0] g;
    logic [COLOR_W_DEF-1:0] b;
  } pixel_t;

  // Total ticks per line (or lines per frame) from the four timing segments.
  function automatic int unsigned line_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  // Replication factor to shift amount; only 1, 2 and 4 are meaningful.
  function automatic int unsigned scale_shift(input int unsigned scale);
    case (scale)
      2:       return 1;
      4:       return 2;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/frame_scanout_timing.sv
// VGA raster counters with raw (undelayed) sync, active flag and vblank-entry strobe.
module frame_scanout_timing
  import frame_scanout_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  localparam int unsigned H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned HCW     = $clog2(H_TOTAL),
  localparam int unsigned VCW     = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pix_en,
  output logic [HCW-1:0] hcnt,
  output logic [VCW-1:0] vcnt,
  output logic           hs_raw,
  output logic           vs_raw,
  output logic           active,
  output logic           vblank_tick
);

  logic [HCW-1:0] hcnt_q;
  logic [VCW-1:0] vcnt_q;
  logic           h_last;
  logic           v_last;

  assign h_last = (hcnt_q == HCW'(H_TOTAL - 1));
  assign v_last = (vcnt_q == VCW'(V_TOTAL - 1));

  // Raster position advances one pixel per pix_en tick, wrapping line then frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hcnt_q <= '0;
        vcnt_q <= v_last ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_q <= hcnt_q + 1'b1;
      end
    end
  end

  assign hcnt   = hcnt_q;
  assign vcnt   = vcnt_q;
  assign hs_raw = ~((hcnt_q >= HCW'(H_ACTIVE + H_FP)) &&
                    (hcnt_q <  HCW'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_raw = ~((vcnt_q >= VCW'(V_ACTIVE + V_FP)) &&
                    (vcnt_q <  VCW'(V_ACTIVE + V_FP + V_SYNC)));
  assign active = (hcnt_q < HCW'(H_ACTIVE)) && (vcnt_q < VCW'(V_ACTIVE));

  // High on the tick whose edge moves the raster to hcnt=0, vcnt=V_ACTIVE.
  assign vblank_tick = pix_en && h_last && (vcnt_q == VCW'(V_ACTIVE - 1));

endmodule

// File: rtl/frame_scanout.sv
// Frame-buffer reader: fetches pixels in raster order from the front buffer,
// aligns RGB with sync on the VGA pins, and swaps buffers at vblank entry.
module frame_scanout
  import frame_scanout_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned SCALE    = SCALE_DEF,
  parameter int unsigned COLOR_W  = COLOR_W_DEF,
  localparam int unsigned BUF_W   = H_ACTIVE / SCALE,
  localparam int unsigned BUF_H   = V_ACTIVE / SCALE,
  localparam int unsigned AW      = $clog2(BUF_W * BUF_H)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_en,
  input  logic                 swap_req,
  output logic                 swap_ack,
  output logic                 refresh,
  output logic                 rd_en,
  output logic                 rd_buf,
  output logic [AW-1:0]        rd_addr,
  input  logic [3*COLOR_W-1:0] rd_data,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_de
);

  localparam int unsigned H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HCW     = $clog2(H_TOTAL);
  localparam int unsigned VCW     = $clog2(V_TOTAL);
  localparam int unsigned SH      = scale_shift(SCALE);

  // Same layout as pixel_t, but sized by this instance's COLOR_W.
  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } pix_t;

  logic [HCW-1:0] hcnt;
  logic [VCW-1:0] vcnt;
  logic           hs_raw;
  logic           vs_raw;
  logic           active;
  logic           vblank_tick;

  frame_scanout_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .active      (active),
    .vblank_tick (vblank_tick)
  );

  // Buffer address: row * BUF_W built as a constant shift-add over BUF_W's set bits.
  logic [AW-1:0] row;
  logic [AW-1:0] col;
  logic [AW-1:0] row_base;
  logic [AW-1:0] fetch_addr;

  always_comb begin
    row      = AW'(vcnt >> SH);
    col      = AW'(hcnt >> SH);
    row_base = '0;
    for (int i = 0; i < 32; i++) begin
      if (BUF_W[i]) row_base = row_base + (row << i);
    end
    fetch_addr = row_base + col;
  end

  // Swap control: a request is latched until the next vblank entry, including
  // one that arrives on the vblank-entry tick itself.
  logic front_q;
  logic pend_q;
  logic refresh_q;
  logic ack_q;
  logic do_swap;

  assign do_swap = vblank_tick && (pend_q || swap_req);

  // Front buffer, pending request and the two per-frame pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_q   <= 1'b0;
      pend_q    <= 1'b0;
      refresh_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      refresh_q <= vblank_tick;
      ack_q     <= do_swap;
      pend_q    <= do_swap ? 1'b0 : (pend_q || swap_req);
      if (do_swap) front_q <= ~front_q;
    end
  end

  // Stage 1: issue the read and delay sync/active by one tick.
  // Address and buffer only move on active fetches, so they hold through blanking.
  logic          rd_en_q;
  logic [AW-1:0] rd_addr_q;
  logic          rd_buf_q;
  logic          hs1_q;
  logic          vs1_q;
  logic          de1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_buf_q  <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      de1_q     <= 1'b0;
    end else begin
      rd_en_q <= pix_en && active;
      if (pix_en) begin
        hs1_q <= hs_raw;
        vs1_q <= vs_raw;
        de1_q <= active;
        if (active) begin
          rd_addr_q <= fetch_addr;
          rd_buf_q  <= front_q;
        end
      end
    end
  end

  // rd_data is sampled on the clk edge following rd_en. When pix_en is high on
  // every clk that same edge is also the stage-2 tick, so stage 2 takes the
  // incoming word directly instead of the not-yet-updated hold register.
  pix_t hold_q;
  pix_t hold_d;

  assign hold_d = rd_en_q ? pix_t'(rd_data) : hold_q;

  // Capture register, running on every clk regardless of pix_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end

  // Stage 2: pin registers; colour blanked outside the active region.
  pix_t rgb_q;
  logic hs2_q;
  logic vs2_q;
  logic de2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
      de2_q <= 1'b0;
    end else if (pix_en) begin
      rgb_q <= de1_q ? hold_d : '0;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      de2_q <= de1_q;
    end
  end

  assign swap_ack = ack_q;
  assign refresh  = refresh_q;
  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign rd_buf   = rd_buf_q;
  assign vga_r    = rgb_q.r;
  assign vga_g    = rgb_q.g;
  assign vga_b    = rgb_q.b;
  assign vga_hs   = hs2_q;
  assign vga_vs   = vs2_q;
  assign vga_de   = de2_q;

endmodule

// File: tb/tb_frame_scanout.sv
// Directed bench for frame_scanout on a shrunken raster (16x8 visible, 24x13 total).
// Memory returns {buf, tag, addr} so the pins reveal which word and buffer were read.
module tb_frame_scanout;

  localparam int unsigned HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int unsigned VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int unsigned CW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic        swap_req = 1'b0;

  logic        swap_ack, refresh, rd_en, rd_buf, vga_hs, vga_vs, vga_de;
  logic [6:0]  rd_addr;
  logic [11:0] rd_data;
  logic [3:0]  vga_r, vga_g, vga_b;

  logic        swap_ack2, refresh2, rd_en2, rd_buf2, vga_hs2, vga_vs2, vga_de2;
  logic [4:0]  rd_addr2;
  logic [11:0] rd_data2;
  logic [3:0]  vga_r2, vga_g2, vga_b2;

  always #5 clk = ~clk;

  assign rd_data  = {rd_buf, 4'b1010, rd_addr};
  assign rd_data2 = {rd_buf2, 6'b100000, rd_addr2};

  frame_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SCALE(1), .COLOR_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .swap_req(swap_req), .swap_ack(swap_ack),
    .refresh(refresh), .rd_en(rd_en), .rd_buf(rd_buf), .rd_addr(rd_addr),
    .rd_data(rd_data), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de)
  );

  frame_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SCALE(2), .COLOR_W(CW)
  ) dut2 (
    .clk(clk), .rst(rst), .pix_en(pix_en), .swap_req(swap_req), .swap_ack(swap_ack2),
    .refresh(refresh2), .rd_en(rd_en2), .rd_buf(rd_buf2), .rd_addr(rd_addr2),
    .rd_data(rd_data2), .vga_r(vga_r2), .vga_g(vga_g2), .vga_b(vga_b2),
    .vga_hs(vga_hs2), .vga_vs(vga_vs2), .vga_de(vga_de2)
  );

  typedef struct {
    int n;      // pix_en ticks since reset release
    int en;     // rd_en (both instances)
    int addr;   // rd_addr, SCALE=1
    int addr2;  // rd_addr, SCALE=2
    int hs, vs, de;
    int rgb;    // {r,g,b}, SCALE=1
    int rgb2;   // {r,g,b}, SCALE=2
    int rf;     // refresh
  } row_t;

  row_t rows[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   ticks   = 0;
  int   gap     = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s (tick %0d, gap %0d): got 'h%0h, want 'h%0h",
                  name, ticks, gap, act, exp);
  endtask

  task automatic add(input int n, input int en, input int addr, input int addr2, input int hs,
                     input int vs, input int de, input int rgb, input int rgb2, input int rf);
    row_t r;
    r.n = n; r.en = en; r.addr = addr; r.addr2 = addr2; r.hs = hs; r.vs = vs; r.de = de;
    r.rgb = rgb; r.rgb2 = rgb2; r.rf = rf;
    rows.push_back(r);
  endtask

  // One pixel tick, preceded by `gap` idle clocks; sampling happens 1 ns after the edge.
  task automatic tick();
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    pix_en = 1'b0;
    ticks++;
  endtask

  task automatic run_to(input int n);
    while (ticks < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pix_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ticks = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_hs"}, int'(vga_hs), 1);
    chk({tag, "_vs"}, int'(vga_vs), 1);
    chk({tag, "_de"}, int'(vga_de), 0);
    chk({tag, "_rgb"}, int'({vga_r, vga_g, vga_b}), 0);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_rd_buf"}, int'(rd_buf), 0);
    chk({tag, "_refresh"}, int'(refresh), 0);
    chk({tag, "_swap_ack"}, int'(swap_ack), 0);
    chk({tag, "_rd_addr2"}, int'(rd_addr2), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //   n    en addr a2  hs vs de rgb     rgb2    rf
    add(1,    1, 0,   0,  1, 1, 0, 0,      0,      0);
    add(2,    1, 1,   0,  1, 1, 1, 'h500, 'h400, 0);
    add(3,    1, 2,   1,  1, 1, 1, 'h501, 'h400, 0);
    add(10,   1, 9,   4,  1, 1, 1, 'h508, 'h404, 0);
    add(17,   0, 15,  7,  1, 1, 1, 'h50F, 'h407, 0);
    add(18,   0, 15,  7,  1, 1, 0, 0,      0,      0);
    add(20,   0, 15,  7,  0, 1, 0, 0,      0,      0);
    add(22,   0, 15,  7,  0, 1, 0, 0,      0,      0);
    add(23,   0, 15,  7,  1, 1, 0, 0,      0,      0);
    add(25,   1, 16,  0,  1, 1, 0, 0,      0,      0);
    add(26,   1, 17,  0,  1, 1, 1, 'h510, 'h400, 0);
    add(49,   1, 32,  8,  1, 1, 0, 0,      0,      0);
    add(50,   1, 33,  8,  1, 1, 1, 'h520, 'h408, 0);
    add(184,  1, 127, 31, 1, 1, 1, 'h57E, 'h41F, 0);
    add(185,  0, 127, 31, 1, 1, 1, 'h57F, 'h41F, 0);
    add(191,  0, 127, 31, 1, 1, 0, 0,      0,      0);
    add(192,  0, 127, 31, 1, 1, 0, 0,      0,      1);
    add(193,  0, 127, 31, 1, 1, 0, 0,      0,      0);
    add(217,  0, 127, 31, 1, 1, 0, 0,      0,      0);
    add(218,  0, 127, 31, 1, 0, 0, 0,      0,      0);
    add(265,  0, 127, 31, 1, 0, 0, 0,      0,      0);
    add(266,  0, 127, 31, 1, 1, 0, 0,      0,      0);
    add(313,  1, 0,   0,  1, 1, 0, 0,      0,      0);
    add(314,  1, 1,   0,  1, 1, 1, 'h500, 'h400, 0);

    // Power-on reset state.
    @(posedge clk);
    #1;
    chk_reset("por");

    // Raster table, first with pix_en on every clk, then on every second clk.
    for (int g = 0; g < 2; g++) begin
      gap = g;
      do_reset();
      foreach (rows[i]) begin
        run_to(rows[i].n);
        chk("rd_en", int'(rd_en), rows[i].en);
        chk("rd_en2", int'(rd_en2), rows[i].en);
        chk("rd_addr", int'(rd_addr), rows[i].addr);
        chk("rd_addr2", int'(rd_addr2), rows[i].addr2);
        chk("vga_hs", int'(vga_hs), rows[i].hs);
        chk("vga_vs", int'(vga_vs), rows[i].vs);
        chk("vga_de", int'(vga_de), rows[i].de);
        chk("rgb", int'({vga_r, vga_g, vga_b}), rows[i].rgb);
        chk("rgb2", int'({vga_r2, vga_g2, vga_b2}), rows[i].rgb2);
        chk("refresh", int'(refresh), rows[i].rf);
        chk("swap_ack", int'(swap_ack), 0);
        if (gap == 1 && rows[i].n == 1) begin
          @(posedge clk);
          #1;
          chk("rd_en_one_clk", int'(rd_en), 0);
        end
      end
    end

    // Swap requested twice mid-frame collapses into one swap at vblank entry.
    gap = 0;
    do_reset();
    run_to(1);
    chk("sw_first_buf", int'(rd_buf), 0);
    run_to(49);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    run_to(99);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    run_to(184);
    chk("sw_last_fetch_en", int'(rd_en), 1);
    chk("sw_last_fetch_buf", int'(rd_buf), 0);
    run_to(191);
    chk("sw_ack_early", int'(swap_ack), 0);
    run_to(192);
    chk("sw_ack", int'(swap_ack), 1);
    chk("sw_refresh", int'(refresh), 1);
    chk("sw_buf_in_vblank", int'(rd_buf), 0);
    run_to(193);
    chk("sw_ack_pulse", int'(swap_ack), 0);
    run_to(313);
    chk("sw_new_en", int'(rd_en), 1);
    chk("sw_new_buf", int'(rd_buf), 1);
    run_to(314);
    chk("sw_new_rgb", int'({vga_r, vga_g, vga_b}), 'hD00);
    run_to(442);
    chk("mid_en", int'(rd_en), 1);
    chk("mid_addr", int'(rd_addr), 89);
    chk("mid_buf", int'(rd_buf), 1);

    // Asynchronous reset mid-line; also held across ticks with a swap request.
    #2;
    rst = 1'b1;
    #1;
    chk_reset("async");
    pix_en = 1'b1;
    swap_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("held");
    swap_req = 1'b0;
    pix_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ticks = 0;
    run_to(1);
    chk("post_rst_en", int'(rd_en), 1);
    chk("post_rst_addr", int'(rd_addr), 0);
    chk("post_rst_buf", int'(rd_buf), 0);

    // Request arriving exactly on the vblank-entry tick is honoured this frame.
    run_to(191);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("late_ack", int'(swap_ack), 1);
    chk("late_refresh", int'(refresh), 1);
    run_to(313);
    chk("late_buf", int'(rd_buf), 1);
    run_to(504);
    chk("noreq_refresh", int'(refresh), 1);
    chk("noreq_ack", int'(swap_ack), 0);
    run_to(625);
    chk("noreq_en", int'(rd_en), 1);
    chk("noreq_buf", int'(rd_buf), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
